// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared encodings for the iterative divider.
//   - div_state_e : FSM state encoding (FREE / BYZERO / ON / END)
//   - DivStart/DivStop, DivResultReady/DivResultNotReady : handshake levels
//   - ZeroWord, RstEnable : common pipeline constants
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic        RstEnable         = 1'b1;

endpackage

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU, one quotient bit per
// cycle. 33 cycles from the start edge to a valid result; divide-by-zero
// returns 0 after one cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   signed_div_i    1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i/2_i   dividend / divisor, sampled only on the start edge
//   start_i         request, held until the result is consumed
//   annul_i         abort, honoured in FREE and ON
//   result_o        {remainder, quotient}
//   ready_o         result valid
import div_unit_pkg::*;

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CntLast = CW'(WIDTH);

  div_state_e         r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  // {remainder[2W:W+1], dividend/quotient[W:1], new quotient bit[0]}
  logic [2*WIDTH:0]   r_work, w_work_nxt;
  logic [WIDTH-1:0]   r_divisor, w_divisor_nxt;
  logic               r_neg_q, w_neg_q_nxt;
  logic               r_neg_r, w_neg_r_nxt;
  logic [2*WIDTH-1:0] r_result, w_result_nxt;
  logic               r_ready, w_ready_nxt;

  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_abs1, w_abs2, w_quot, w_rem;
  logic               w_go;

  assign result_o = r_result;
  assign ready_o  = r_ready;

  assign w_go = (start_i == DivStart) && !annul_i;

  // Magnitudes; -0x80000000 wraps to 0x80000000, which is the correct
  // unsigned magnitude, so the most-negative operand needs no special case.
  assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // 33-bit compare of the shifted partial remainder against the divisor;
  // bit WIDTH set means the trial subtraction went negative.
  assign w_diff = r_work[2*WIDTH:WIDTH] - {1'b0, r_divisor};

  assign w_quot = r_neg_q ? -r_work[WIDTH-1:0]       : r_work[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_work[2*WIDTH:WIDTH+1] : r_work[2*WIDTH:WIDTH+1];

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state   <= DivFree;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
      r_ready   <= DivResultNotReady;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_work    <= w_work_nxt;
      r_divisor <= w_divisor_nxt;
      r_neg_q   <= w_neg_q_nxt;
      r_neg_r   <= w_neg_r_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      DivFree:   if (w_go) w_state_nxt = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
      DivByZero: w_state_nxt = DivEnd;
      DivOn: begin
        if (annul_i)               w_state_nxt = DivFree;
        else if (r_cnt == CntLast) w_state_nxt = DivEnd;
      end
      DivEnd:    if (start_i == DivStop) w_state_nxt = DivFree;
      default:   w_state_nxt = DivFree;
    endcase
  end

  // Output / datapath next values (registered above)
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_work_nxt    = r_work;
    w_divisor_nxt = r_divisor;
    w_neg_q_nxt   = r_neg_q;
    w_neg_r_nxt   = r_neg_r;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;
    unique case (r_state)
      DivFree: begin
        w_result_nxt = '0;
        w_ready_nxt  = DivResultNotReady;
        w_cnt_nxt    = '0;
        if (w_go) begin
          w_divisor_nxt = w_abs2;
          w_work_nxt    = {{WIDTH{1'b0}}, w_abs1, 1'b0};
          w_neg_q_nxt   = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          w_neg_r_nxt   = signed_div_i && opdata1_i[WIDTH-1];
        end
      end
      DivByZero: begin
        w_result_nxt = '0;
        w_ready_nxt  = DivResultReady;
      end
      DivOn: begin
        if (annul_i) begin
          w_cnt_nxt    = '0;
          w_result_nxt = '0;
          w_ready_nxt  = DivResultNotReady;
        end else if (r_cnt != CntLast) begin
          if (w_diff[WIDTH]) w_work_nxt = {r_work[2*WIDTH-1:0], 1'b0};
          else               w_work_nxt = {w_diff[WIDTH-1:0], r_work[WIDTH-1:0], 1'b1};
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_result_nxt = {w_rem, w_quot};
          w_ready_nxt  = DivResultReady;
          w_cnt_nxt    = '0;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          w_result_nxt = '0;
          w_ready_nxt  = DivResultNotReady;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit restoring divider used by the execute stage for DIV/DIVU.
- Execute decodes ex_aluop from the ID/EX register and drives start_i/operands.
- Execute holds a stall request while ready_o is low and forwards result_o to the HI/LO write path.
- One quotient bit per cycle; the unit does not use the ctrl stall vector.

Parameters:
- WIDTH, 32, operand width. Only 32 is verified.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request; held high by execute until it consumes the result
- annul_i  in  1  abort (flush/exception); sampled in ON and FREE
- result_o  out  64  {remainder[63:32], quotient[31:0]}; HI = remainder, LO = quotient
- ready_o  out  1  result valid

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset: state = FREE, cnt = 0, result_o = 0, ready_o = 0.
- Reset has priority over all inputs and aborts any operation in progress.
- All outputs are registered.
- State machine has four states: FREE, BYZERO, ON, END.
- FREE, start_i & !annul_i:
  - If opdata2_i == 0, go to BYZERO.
  - Otherwise go to ON, with cnt = 0.
  - Latch divisor = |opdata2_i| if signed_div_i, else opdata2_i.
  - Load the 65-bit work register with {32'b0, |dividend|, 1'b0} for signed, or the raw dividend for unsigned.
  - Operands are ignored after this edge.
  - ready_o = 0, result_o = 0.
- FREE, start_i & annul_i: stay in FREE.
- BYZERO: next edge goes to END with result_o = 0 and ready_o = 1.
- ON, annul_i = 1: next edge goes to FREE, cnt = 0, ready_o stays 0, partial result is discarded.
- ON, cnt < 32, per edge:
  - diff = work[64:32] - {1'b0, divisor} (33-bit).
  - If diff is negative: work = work << 1.
  - Otherwise: work = {diff[31:0], work[31:0], 1'b1}.
  - cnt++.
- ON, cnt == 32: sign fixup, then next edge goes to END.
  - quotient = work[31:0], negated if signed and dividend/divisor signs differ.
  - remainder = work[64:33], negated if signed and the dividend is negative.
  - result_o and ready_o = 1 are written on that edge; cnt = 0.
- Latency: start is sampled at edge E0; ready_o is high after edge E33 (33 cycles). Divide-by-zero: ready_o is high after edge E1.
- END: ready_o = 1 and result_o are held while start_i = 1. When start_i = 0, the next edge goes to FREE with ready_o = 0 and result_o = 0.
- END ignores annul_i. Execute deasserts start_i to release the unit.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This is deterministic; the architecture leaves it unpredictable.
- |0x80000000| is treated as unsigned 0x80000000; no overflow in the magnitude path.
- start_i rising in ON or BYZERO has no effect; the operation continues.

Decomposition:
- Shared defines file holds:
  - State encodings: DivFree = 2'b00, DivByZero = 2'b01, DivOn = 2'b10, DivEnd = 2'b11.
  - DivStart / DivStop, DivResultReady / DivResultNotReady.
  - Existing ZeroWord and RstEnable.
- No sub-module. The step subtractor is inline. Execute owns stall generation and the op decode for signed_div_i.

Test Plan:
- Unsigned 100 / 7, start held → ready_o rises after E33; result_o = 0x00000002_0000000E. Held while start = 1; after start = 0, next edge gives ready = 0, result = 0.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) → result_o = 0xFFFFFFFF_FFFFFFFD (rem -1, quot -3). Also signed 7 / -2 → 0x00000001_FFFFFFFD.
- Divisor 0, any dividend → BYZERO; ready_o = 1 after E1, result_o = 0.
- annul_i pulsed at cnt = 10 → FREE next edge; ready_o never asserted. An immediate new start of 0xFFFFFFFF / 0x10 unsigned gives 0x0000000F_0FFFFFFF after 33 cycles.
- rst asserted at cnt = 20 → next edge FREE, outputs 0. Operand changes during ON do not alter the result (change opdata1_i at cnt = 5 → original result).
- Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000; unsigned 0x80000000 / 0xFFFFFFFF → 0x80000000_00000000.
